// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Package  : clock_pkg
// Brief    : Shared state encoding, BCD limits and auto-repeat timing for the
//            clock time-setting controller.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam logic [7:0] HRS_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;

    localparam int c_REPEAT_FIRST_MS = 500;
    localparam int c_REPEAT_NEXT_MS  = 150;

    // Wraps to 00 at the limit, otherwise carries units 9 into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        if (val == max) begin
            return 8'h00;
        end
        if (val[3:0] == 4'd9) begin
            return {val[7:4] + 4'd1, 4'd0};
        end
        return {val[7:4], val[3:0] + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer, stability debouncer and press-event pulse
//            for one active-low push button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYC = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_btn_n,
    output logic o_press,
    output logic o_held
);

    localparam int c_CNT_MAX = (DB_CYC < 1) ? 0 : DB_CYC - 1;
    localparam int c_CNT_W   = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            o_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            o_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(c_CNT_MAX)) begin
                // Only the released-to-pressed change produces an event.
                r_level <= r_sync[1];
                r_cnt   <= '0;
                o_press <= r_level;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_held = ~r_level;

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : Two-button hour/minute setting controller with blinking edit
//            digits, idle timeout and one-cycle load strobe to the datapath.
// Config   : define AUTO_REPEAT_EN to enable auto-repeat of a held inc button.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = 27000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_S   = 30,
    parameter int BLINK_HZ    = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [7:0] cur_hrs,
    input  logic [7:0] cur_min,
    output logic [7:0] set_hrs,
    output logic [7:0] set_min,
    output logic       load,
    output logic       hold_run,
    output logic       blank_hrs,
    output logic       blank_min,
    output logic [1:0] mode
);

    localparam int c_DB_CYC      = int'(longint'(DEBOUNCE_MS) * longint'(CLK_HZ) / 1000);
    localparam int c_TIMEOUT_CYC = int'(longint'(TIMEOUT_S) * longint'(CLK_HZ));
    localparam int c_IDLE_W      = $clog2(c_TIMEOUT_CYC + 1);
    localparam int c_BLINK_RAW   = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_BLINK_HALF  = (c_BLINK_RAW < 1) ? 1 : c_BLINK_RAW;
    localparam int c_BLINK_W     = $clog2(c_BLINK_HALF + 1);

    logic w_mode_ev;
    logic w_inc_press;
    logic w_inc_ev;
    logic w_inc_held;
    logic w_unused_mode_held;
    logic w_edit;
    logic w_timeout;
    logic w_inc_taken;
    logic w_blink_restart;
    logic w_nxt_blink;
    logic [c_BLINK_W-1:0] w_nxt_blink_cnt;
    logic [7:0] w_nxt_hrs;
    logic [7:0] w_nxt_min;
    state_t w_nxt_state;

    state_t               r_state;
    logic [c_IDLE_W-1:0]  r_idle;
    logic                 r_blink;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    btn_debounce #(.DB_CYC(c_DB_CYC)) u_db_mode (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_btn_n   (btn_mode_n),
        .o_press   (w_mode_ev),
        .o_held    (w_unused_mode_held)
    );

    btn_debounce #(.DB_CYC(c_DB_CYC)) u_db_inc (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_btn_n   (btn_inc_n),
        .o_press   (w_inc_press),
        .o_held    (w_inc_held)
    );

    assign w_edit = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_FIRST_CYC = c_REPEAT_FIRST_MS * (CLK_HZ / 1000);
    localparam int c_REP_NEXT_CYC  = c_REPEAT_NEXT_MS * (CLK_HZ / 1000);
    localparam int c_REP_MAX       = (c_REP_FIRST_CYC > c_REP_NEXT_CYC) ? c_REP_FIRST_CYC : c_REP_NEXT_CYC;
    localparam int c_REP_W         = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic               w_rep_ev;

    assign w_rep_ev = w_inc_held && w_edit &&
                      (r_rep_cnt == (r_rep_first ? c_REP_W'(c_REP_FIRST_CYC) : c_REP_W'(c_REP_NEXT_CYC)));

    // Counts held cycles since the press event, or since the last repeat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (!w_inc_held || !w_edit) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_ev) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
        end
    end

    assign w_inc_ev = w_inc_press | w_rep_ev;
`else
    logic w_unused_inc_held;
    assign w_unused_inc_held = w_inc_held;
    assign w_inc_ev          = w_inc_press;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hrs   = set_hrs;
        w_nxt_min   = set_min;
        w_timeout   = (r_idle == c_IDLE_W'(c_TIMEOUT_CYC - 1));
        case (r_state)
            ST_RUN: begin
                if (w_mode_ev) begin
                    w_nxt_state = ST_SET_HR;
                    w_nxt_hrs   = cur_hrs;
                    w_nxt_min   = cur_min;
                end
            end
            ST_SET_HR: begin
                if (w_mode_ev)      w_nxt_state = ST_SET_MIN;
                else if (w_inc_ev)  w_nxt_hrs   = bcd_inc(set_hrs, HRS_MAX);
                else if (w_timeout) w_nxt_state = ST_RUN;
            end
            ST_SET_MIN: begin
                if (w_mode_ev)      w_nxt_state = ST_COMMIT;
                else if (w_inc_ev)  w_nxt_min   = bcd_inc(set_min, MIN_MAX);
                else if (w_timeout) w_nxt_state = ST_RUN;
            end
            default: w_nxt_state = ST_RUN;
        endcase

        w_inc_taken     = w_edit && w_inc_ev && !w_mode_ev;
        w_blink_restart = (w_nxt_state != r_state) || w_inc_taken;
        w_nxt_blink     = r_blink;
        w_nxt_blink_cnt = r_blink_cnt + c_BLINK_W'(1);
        if (w_blink_restart) begin
            w_nxt_blink     = 1'b0;
            w_nxt_blink_cnt = '0;
        end else if (r_blink_cnt == c_BLINK_W'(c_BLINK_HALF - 1)) begin
            w_nxt_blink     = ~r_blink;
            w_nxt_blink_cnt = '0;
        end
    end

    // Outputs are registered from next-state values so they align with mode.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_RUN;
            r_idle      <= '0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
            set_hrs     <= 8'h00;
            set_min     <= 8'h00;
            load        <= 1'b0;
            hold_run    <= 1'b0;
            blank_hrs   <= 1'b0;
            blank_min   <= 1'b0;
            mode        <= 2'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_blink     <= w_nxt_blink;
            r_blink_cnt <= w_nxt_blink_cnt;
            set_hrs     <= w_nxt_hrs;
            set_min     <= w_nxt_min;
            load        <= (w_nxt_state == ST_COMMIT);
            hold_run    <= (w_nxt_state != ST_RUN);
            blank_hrs   <= (w_nxt_state == ST_SET_HR) && w_nxt_blink;
            blank_min   <= (w_nxt_state == ST_SET_MIN) && w_nxt_blink;
            mode        <= w_nxt_state;
            if (w_mode_ev || w_inc_ev || (w_nxt_state != r_state) || !w_edit) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_IDLE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Brief    : Scoreboard bench for clock_set_ctrl; expected output snapshots are
//            queued by a reference model, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    localparam int CLK_HZ      = 1000;
    localparam int DEBOUNCE_MS = 5;
    localparam int TIMEOUT_S   = 2;
    localparam int BLINK_HZ    = 100;
    localparam int c_HALF      = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_DB        = DEBOUNCE_MS * CLK_HZ / 1000;
    localparam int c_TO        = TIMEOUT_S * CLK_HZ;
    localparam int c_REP_FIRST = 500 * CLK_HZ / 1000;
    localparam int c_REP_NEXT  = 150 * CLK_HZ / 1000;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_inc_n  = 1'b1;
    logic [7:0] cur_hrs    = 8'h00;
    logic [7:0] cur_min    = 8'h00;
    logic [7:0] set_hrs;
    logic [7:0] set_min;
    logic       load;
    logic       hold_run;
    logic       blank_hrs;
    logic       blank_min;
    logic [1:0] mode;

    always #5 sys_clk = ~sys_clk;

    clock_set_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .TIMEOUT_S   (TIMEOUT_S),
        .BLINK_HZ    (BLINK_HZ)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .btn_mode_n (btn_mode_n),
        .btn_inc_n  (btn_inc_n),
        .cur_hrs    (cur_hrs),
        .cur_min    (cur_min),
        .set_hrs    (set_hrs),
        .set_min    (set_min),
        .load       (load),
        .hold_run   (hold_run),
        .blank_hrs  (blank_hrs),
        .blank_min  (blank_min),
        .mode       (mode)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] hrs;
        logic [7:0] mins;
        logic       load;
    } snap_t;

    snap_t exp_q[$];
    snap_t e;
    int    checks = 0;
    int    errors = 0;

    // Reference model: state number and plain decimal hours/minutes.
    int m_state = 0;
    int m_h     = 0;
    int m_m     = 0;

    bit         mon_en = 1'b0;
    logic [1:0] prev_mode;
    logic [7:0] prev_h, prev_m;
    logic       prev_ld;
    time        t_last_change = 0;
    int         blink_k = 0;
    bit         blink_bad = 1'b0;
    int         bad_k = 0;
    logic [1:0] bad_val = 2'b00;
    logic [1:0] blink_mode = 2'd0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic push(input int st, input bit ld);
        snap_t s;
        s.mode = 2'(st);
        s.hrs  = to_bcd(m_h);
        s.mins = to_bcd(m_m);
        s.load = ld;
        exp_q.push_back(s);
    endtask

    task automatic model_event(input bit m, input bit i, input int hold);
        int n;
        if (hold < c_DB) return;
        if (m) begin
            case (m_state)
                0: begin
                    m_h = from_bcd(cur_hrs);
                    m_m = from_bcd(cur_min);
                    m_state = 1;
                    push(1, 1'b0);
                end
                1: begin
                    m_state = 2;
                    push(2, 1'b0);
                end
                default: begin
                    push(3, 1'b1);
                    m_state = 0;
                    push(0, 1'b0);
                end
            endcase
        end else if (i && m_state != 0) begin
            n = 1;
`ifdef AUTO_REPEAT_EN
            if (hold > c_REP_FIRST) n += (hold - c_REP_FIRST - 1) / c_REP_NEXT + 1;
`endif
            repeat (n) begin
                if (m_state == 1) m_h = (m_h + 1) % 24;
                else              m_m = (m_m + 1) % 60;
                push(m_state, 1'b0);
            end
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge sys_clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs still pending after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_press(input bit m, input bit i, input int hold);
        model_event(m, i, hold);
        @(posedge sys_clk);
        #1;
        if (m) btn_mode_n = 1'b0;
        if (i) btn_inc_n  = 1'b0;
        repeat (hold) @(posedge sys_clk);
        #1;
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        repeat (c_DB + 8) @(posedge sys_clk);
        wait_drain(50);
    endtask

    task automatic close_blink();
        if (blink_k > 0) begin
            checks++;
            if (blink_bad) begin
                errors++;
                $display("FAIL blink: mode %0d cycle %0d after change got blank_hrs/min=%b expected hrs=%0d min=%0d",
                         blink_mode, bad_k, bad_val,
                         (blink_mode == 2'd1) ? (bad_k / c_HALF) % 2 : 0,
                         (blink_mode == 2'd2) ? (bad_k / c_HALF) % 2 : 0);
            end
        end
    endtask

    task automatic check_reset(input string name);
        check_eq(name, {10'd0, mode, set_hrs, set_min, load, hold_run, blank_hrs, blank_min}, 32'd0);
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            logic exp_hb;
            logic exp_mb;
            if ({mode, set_hrs, set_min, load} != {prev_mode, prev_h, prev_m, prev_ld}) begin
                close_blink();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got mode=%0d hrs=%h min=%h load=%b, none expected",
                             mode, set_hrs, set_min, load);
                end else begin
                    e = exp_q.pop_front();
                    if (mode !== e.mode || set_hrs !== e.hrs || set_min !== e.mins || load !== e.load ||
                        hold_run !== (e.mode != 2'd0) || blank_hrs !== 1'b0 || blank_min !== 1'b0) begin
                        errors++;
                        $display("FAIL snapshot: got mode=%0d hrs=%h min=%h load=%b hold=%b blank=%b%b expected mode=%0d hrs=%h min=%h load=%b hold=%b blank=00",
                                 mode, set_hrs, set_min, load, hold_run, blank_hrs, blank_min,
                                 e.mode, e.hrs, e.mins, e.load, (e.mode != 2'd0));
                    end
                end
                prev_mode = mode; prev_h = set_hrs; prev_m = set_min; prev_ld = load;
                blink_k = 0; blink_bad = 1'b0; blink_mode = mode;
                t_last_change = $time;
            end
            exp_hb = (mode == 2'd1) ? 1'((blink_k / c_HALF) % 2) : 1'b0;
            exp_mb = (mode == 2'd2) ? 1'((blink_k / c_HALF) % 2) : 1'b0;
            if ((blank_hrs !== exp_hb || blank_min !== exp_mb) && !blink_bad) begin
                blink_bad = 1'b1;
                bad_k     = blink_k;
                bad_val   = {blank_hrs, blank_min};
            end
            blink_k++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   delta;
        time  t_entry;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset("reset_initial");
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        prev_mode = mode; prev_h = set_hrs; prev_m = set_min; prev_ld = load;
        mon_en = 1'b1;

        // inc in RUN is ignored
        do_press(1'b0, 1'b1, 10);

        // 23:58 -> 00:00 wrap and commit
        cur_hrs = 8'h23; cur_min = 8'h58;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b1, 1'b0, 10);
        check_eq("commit_mode_run", 32'(mode), 32'd0);

        // glitch rejection and simultaneous mode+inc in SET_HR
        cur_hrs = 8'h12; cur_min = 8'h34;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 3);
        check_eq("glitch_hrs", 32'(set_hrs), 32'(to_bcd(m_h)));
        do_press(1'b1, 1'b1, 10);
        check_eq("simul_mode", 32'(mode), 32'd2);
        check_eq("simul_hrs", 32'(set_hrs), 32'h12);
        do_press(1'b1, 1'b0, 10);

        // idle timeout from SET_MIN
        cur_hrs = 8'h07; cur_min = 8'h45;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b1, 1'b0, 10);
        t_entry = t_last_change;
        m_state = 0;
        push(0, 1'b0);
        k = 0;
        while (mode != 2'd0 && k < c_TO + 600) begin
            @(negedge sys_clk);
            k++;
        end
        @(posedge sys_clk);
        delta = int'((t_last_change - t_entry) / 10);
        checks++;
        if (mode != 2'd0 || delta < c_TO - 2 || delta > c_TO + 2) begin
            errors++;
            $display("FAIL timeout: got mode=%0d after %0d cycles expected mode=0 after %0d cycles", mode, delta, c_TO);
        end
        wait_drain(50);

        // held inc in SET_MIN from 00
        cur_hrs = 8'h05; cur_min = 8'h00;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 950);
        check_eq("held_inc_min", 32'(set_min), 32'(to_bcd(m_m)));
        do_press(1'b1, 1'b0, 10);

        // randomized edit sessions
        for (int s = 0; s < 8; s++) begin
            int nh;
            int nm;
            cur_hrs = to_bcd($urandom_range(0, 23));
            cur_min = to_bcd($urandom_range(0, 59));
            if ($urandom_range(0, 1) == 1) do_press(1'b0, 1'b1, $urandom_range(8, 20));
            do_press(1'b1, 1'b0, $urandom_range(8, 20));
            nh = $urandom_range(0, 5);
            repeat (nh) do_press(1'b0, 1'b1, $urandom_range(8, 30));
            do_press(1'b1, 1'b0, $urandom_range(8, 20));
            nm = $urandom_range(0, 5);
            repeat (nm) do_press(1'b0, 1'b1, $urandom_range(8, 30));
            do_press(1'b1, 1'b0, $urandom_range(8, 20));
        end

        // reset mid-edit in SET_MIN
        cur_hrs = 8'h19; cur_min = 8'h09;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        m_state = 0; m_h = 0; m_m = 0;
        push(0, 1'b0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_reset("reset_mid_edit");
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (100) @(posedge sys_clk);
        check_eq("post_reset_idle", {29'd0, load, mode}, 32'd0);
        wait_drain(10);

        // normal operation after reset
        cur_hrs = 8'h09; cur_min = 8'h59;
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b1, 1'b0, 10);
        do_press(1'b0, 1'b1, 10);
        do_press(1'b1, 1'b0, 10);

        wait_drain(50);
        @(negedge sys_clk);
        mon_en = 1'b0;
        close_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 27000000, sys_clk frequency in Hz; all timing parameters derive from it.
REQ-002 Parameter DEBOUNCE_MS, default 20, time a button must be stable before a level change is accepted.
REQ-003 Parameter TIMEOUT_S, default 30, idle time in the set states before the edit is abandoned.
REQ-004 Parameter BLINK_HZ, default 2, blink toggle rate of the digits being edited.
REQ-005 sys_clk  input  1  clock.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 btn_mode_n  input  1  raw mode button, asynchronous, active-low.
REQ-008 btn_inc_n  input  1  raw increment button, asynchronous, active-low.
REQ-009 cur_hrs  input  8  live BCD hours from the clock datapath: [7:4] tens, [3:0] units.
REQ-010 cur_min  input  8  live BCD minutes from the clock datapath: [7:4] tens, [3:0] units.
REQ-011 set_hrs  output  8  BCD hours shadow value being edited.
REQ-012 set_min  output  8  BCD minutes shadow value being edited.
REQ-013 load  output  1  one-cycle strobe; the datapath takes set_hrs/set_min and clears seconds and the 1 Hz prescaler.
REQ-014 hold_run  output  1  high in every non-RUN state; the datapath freezes timekeeping while it is high.
REQ-015 blank_hrs  output  1  display blanking for the hour digits.
REQ-016 blank_min  output  1  display blanking for the minute digits.
REQ-017 mode  output  2  current state encoding.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer and a debouncer; the accepted level changes only after DEBOUNCE_MS*CLK_HZ/1000 consecutive equal samples.
REQ-019 A press event SHALL be a one-cycle pulse on the accepted high-to-low transition; release SHALL generate no event.
REQ-020 The state machine SHALL have four states with these mode encodings: RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.
REQ-021 RUN: a mode press SHALL copy cur_hrs/cur_min into set_hrs/set_min in the same cycle and move to SET_HR; inc presses SHALL be ignored.
REQ-022 SET_HR: an inc press SHALL increment set_hrs in BCD, with 09->10, 19->20 and 23->00; a mode press SHALL move to SET_MIN.
REQ-023 SET_MIN: an inc press SHALL increment set_min in BCD, with 09->10 and 59->00; a mode press SHALL move to COMMIT.
REQ-024 COMMIT: load SHALL be high for exactly one cycle, then the machine SHALL return to RUN; load SHALL never be asserted in any other state.
REQ-025 When mode and inc press events occur in the same cycle, mode SHALL take effect and the inc event SHALL be discarded.
REQ-026 The idle counter SHALL clear on any press event and on entry to SET_HR; when it reaches TIMEOUT_S*CLK_HZ, the machine SHALL return to RUN without asserting load.
REQ-027 The blink flag SHALL toggle every CLK_HZ/(2*BLINK_HZ) cycles and SHALL restart low on every state change and every inc event.
REQ-028 Blanking SHALL follow the blink flag: blank_hrs = blink in SET_HR, and blank_min = blink in SET_MIN; both SHALL be 0 in all other states.
REQ-029 All outputs SHALL be registered; hold_run SHALL be asserted in the same cycle that mode leaves 0.

Reset
REQ-030 While sys_rst_n is low: mode=RUN, set_hrs=8'h00, set_min=8'h00, load=0, hold_run=0, blank_hrs=0, blank_min=0, and all counters and debouncers cleared with the accepted button level released.
REQ-031 A reset asserted mid-edit SHALL discard the shadow values; load SHALL NOT be asserted at or after reset release.

Configuration
REQ-032 With AUTO_REPEAT_EN defined, holding inc in SET_HR or SET_MIN SHALL generate a first extra inc event after 500 ms, then one event every 150 ms until release; each generated event SHALL also clear the idle counter.
REQ-033 Without AUTO_REPEAT_EN, a held button SHALL produce exactly one inc event, and no repeat logic SHALL be synthesized.

Structure
REQ-034 The shared package clock_pkg SHALL hold the state enum and its encodings, the BCD limits (HRS_MAX=8'h23, MIN_MAX=8'h59), and the auto-repeat timing constants.
REQ-035 The synchronizer, debouncer and press-event logic SHALL be a sub-module, btn_debounce, instantiated once per button.

Verification
REQ-036 Bench parameters SHALL be CLK_HZ=1000, DEBOUNCE_MS=5, TIMEOUT_S=2, BLINK_HZ=100.
REQ-037 With cur_hrs=8'h23 and cur_min=8'h58, the sequence mode, inc, mode, inc, inc, mode -> load high for one cycle with set_hrs=8'h00 and set_min=8'h00, then mode=0.
REQ-038 A 3-cycle glitch on btn_inc_n in SET_HR -> set_hrs unchanged.
REQ-039 Enter SET_MIN, then no presses for 2000 cycles -> mode=0, load never asserted, hold_run=0.
REQ-040 Mode and inc press events in the same cycle in SET_HR -> mode=2 and set_hrs unchanged.
REQ-041 sys_rst_n pulsed low while in SET_MIN -> all outputs at their reset values, and no load within 100 cycles after release.
REQ-042 With AUTO_REPEAT_EN defined, inc held for 950 ms in SET_MIN starting at 8'h00 -> set_min=8'h04.
